instruction_fetch: RTL and testbench

Instruction fetch unit for the simple processor. It owns the program counter and drives the word address into the instruction memory. It captures the returned 32-bit instruction after a fixed memory latency and presents it, tagged with its address, to the decode stage over a valid/ready handshake. It also supports branch redirects, and it halts when it fetches the all-zero word, which marks the end of the program.

---
 rtl/instruction_fetch.sv | 107 ++++++++++
 tb/tb_instruction_fetch.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: owns the PC, drives the instruction-memory word address and
// hands captured instructions to decode over valid/ready, with redirect and halt-on-zero.
module instruction_fetch #(
    parameter int unsigned MEM_LATENCY = 1,
    parameter logic [31:0] RESET_PC    = 32'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [31:0] Read_Addr,
    input  logic [31:0] instruction,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t        state;
    logic [AW-1:0] pc;
    logic [CW-1:0] wait_cnt;

    logic          accept_c;
    logic          sample_c;
    logic [AW-1:0] pc_inc_c;

    assign accept_c = inst_valid & inst_ready;
    assign sample_c = (wait_cnt == CW'(MEM_LATENCY));
    assign pc_inc_c = pc + AW'(1);

    // Redirect overrides every state; the address register only moves on FETCH entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            Read_Addr  <= RESET_PC;
            inst_out   <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
            halted     <= 1'b0;
            wait_cnt   <= '0;
        end else if (redirect) begin
            state      <= FETCH;
            pc         <= redirect_pc;
            Read_Addr  <= redirect_pc;
            wait_cnt   <= '0;
            inst_valid <= 1'b0;
            halted     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FETCH;
                        pc        <= RESET_PC;
                        Read_Addr <= RESET_PC;
                        wait_cnt  <= '0;
                    end
                end
                FETCH: begin
                    if (sample_c) begin
                        wait_cnt <= '0;
                        if (instruction != DW'(0)) begin
                            inst_out   <= instruction;
                            inst_pc    <= pc;
                            inst_valid <= 1'b1;
                            state      <= VALID;
                        end else begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                VALID: begin
                    if (accept_c) begin
                        pc         <= pc_inc_c;
                        Read_Addr  <= pc_inc_c;
                        inst_valid <= 1'b0;
                        wait_cnt   <= '0;
                        state      <= FETCH;
                    end
                end
                HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: two instances (latency 1 and 3) on shared stimulus, each
// checked every cycle against a transaction-level reference, plus literal scenario checks.
module tb_instruction_fetch;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic [31:0] ra1, instr1, io1, ip1;
    logic [31:0] ra3, instr3, io3, ip3;
    logic        iv1, h1, iv3, h3;

    logic [31:0] mem [16];
    logic [31:0] p1;
    logic [31:0] p3 [3];

    int n_pass;
    int n_tot;
    int cyc;

    localparam int MI = 0;
    localparam int MF = 1;
    localparam int MV = 2;
    localparam int MH = 3;

    typedef struct {
        int          mode;
        int          left;
        logic [31:0] pc;
        logic [31:0] ra;
        logic [31:0] out;
        logic [31:0] opc;
        logic        valid;
        logic        halted;
    } mdl_t;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic [31:0] w;
    } hs_t;

    mdl_t m1, m3;
    hs_t  q1[$];
    hs_t  q3[$];

    instruction_fetch #(.MEM_LATENCY(1)) d1 (
        .clk(clk), .reset_n(reset_n), .start(start), .Read_Addr(ra1),
        .instruction(instr1), .inst_out(io1), .inst_pc(ip1), .inst_valid(iv1),
        .inst_ready(inst_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .halted(h1)
    );

    instruction_fetch #(.MEM_LATENCY(3)) d3 (
        .clk(clk), .reset_n(reset_n), .start(start), .Read_Addr(ra3),
        .instruction(instr3), .inst_out(io3), .inst_pc(ip3), .inst_valid(iv3),
        .inst_ready(inst_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .halted(h3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns the word at an address presented N edges earlier.
    always @(posedge clk) begin
        p1    <= ra1;
        p3[0] <= ra3;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign instr1 = mem[p1[3:0]];
    assign instr3 = mem[p3[2][3:0]];

    function automatic mdl_t mreset();
        mdl_t m;
        m.mode = MI; m.left = 0; m.pc = 32'd0; m.ra = 32'd0;
        m.out = 32'd0; m.opc = 32'd0; m.valid = 1'b0; m.halted = 1'b0;
        return m;
    endfunction

    // Reference: a fetch begun on edge k delivers its word on edge k+lat+1.
    function automatic mdl_t mstep(mdl_t m, int lat, logic st, logic rdy, logic rd,
                                   logic [31:0] rpc);
        mdl_t n;
        logic [31:0] w;
        n = m;
        if (rd) begin
            n.mode = MF; n.left = lat + 1; n.pc = rpc; n.ra = rpc;
            n.valid = 1'b0; n.halted = 1'b0;
        end else begin
            case (m.mode)
                MI: if (st) begin
                    n.mode = MF; n.left = lat + 1; n.pc = 32'd0; n.ra = 32'd0;
                end
                MF: begin
                    n.left = m.left - 1;
                    if (n.left == 0) begin
                        w = mem[m.pc[3:0]];
                        if (w != 32'd0) begin
                            n.out = w; n.opc = m.pc; n.valid = 1'b1; n.mode = MV;
                        end else begin
                            n.halted = 1'b1; n.mode = MH;
                        end
                    end
                end
                MV: if (rdy) begin
                    n.pc = m.pc + 32'd1; n.ra = m.pc + 32'd1; n.valid = 1'b0;
                    n.mode = MF; n.left = lat + 1;
                end
                default: ;
            endcase
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic cmp_all();
        chk("d1.Read_Addr", ra1, m1.ra);
        chk("d1.inst_out", io1, m1.out);
        chk("d1.inst_pc", ip1, m1.opc);
        chk("d1.inst_valid", 32'(iv1), 32'(m1.valid));
        chk("d1.halted", 32'(h1), 32'(m1.halted));
        chk("d3.Read_Addr", ra3, m3.ra);
        chk("d3.inst_out", io3, m3.out);
        chk("d3.inst_pc", ip3, m3.opc);
        chk("d3.inst_valid", 32'(iv3), 32'(m3.valid));
        chk("d3.halted", 32'(h3), 32'(m3.halted));
    endtask

    task automatic cycle(input logic st, input logic rdy, input logic rd, input logic [31:0] rpc);
        hs_t e;
        start = st; inst_ready = rdy; redirect = rd; redirect_pc = rpc;
        if (iv1 && rdy) begin
            e.cyc = cyc + 1; e.pc = ip1; e.w = io1; q1.push_back(e);
        end
        if (iv3 && rdy) begin
            e.cyc = cyc + 1; e.pc = ip3; e.w = io3; q3.push_back(e);
        end
        @(posedge clk);
        m1 = mstep(m1, 1, st, rdy, rd, rpc);
        m3 = mstep(m3, 3, st, rdy, rd, rpc);
        cyc++;
        @(negedge clk);
        cmp_all();
    endtask

    // Reset pulse placed between edges; outputs must clear without a clock.
    task automatic do_reset();
        start = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        #1 reset_n = 1'b0;
        #1;
        m1 = mreset();
        m3 = mreset();
        cmp_all();
        chk("rst_d1_valid", 32'(iv1), 32'd0);
        chk("rst_d1_halted", 32'(h1), 32'd0);
        chk("rst_d1_addr", ra1, 32'd0);
        #1 reset_n = 1'b1;
    endtask

    task automatic wait_valid(input logic rdy, input string nm);
        int k;
        k = 0;
        while (!iv1 && k < 20) begin
            cycle(1'b0, rdy, 1'b0, 32'd0);
            k++;
        end
        chk(nm, 32'(iv1), 32'd1);
    endtask

    initial begin
        logic [31:0] prog [3];
        int s;
        logic st, rdy, rd;
        logic [31:0] rpc;

        n_pass = 0; n_tot = 0; cyc = 0;
        reset_n = 1'b1; start = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        prog[0] = 32'h200400FF; prog[1] = 32'h200600AA; prog[2] = 32'h200300BB;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0A000000 | 32'(i);
        mem[0] = prog[0]; mem[1] = prog[1]; mem[2] = prog[2];
        mem[3] = 32'd0; mem[7] = 32'h41040703; mem[8] = 32'd0;
        m1 = mreset();
        m3 = mreset();
        do_reset();

        // Sequential program with decode always ready
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        s = cyc;
        repeat (24) cycle(1'b0, 1'b1, 1'b0, 32'd0);
        chk("a_d1_count", 32'(q1.size()), 32'd3);
        chk("a_d3_count", 32'(q3.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < q1.size()) begin
                chk("a_d1_pc", q1[i].pc, 32'(i));
                chk("a_d1_word", q1[i].w, prog[i]);
                chk("a_d1_edge", 32'(q1[i].cyc), 32'(s + 3 + 3 * i));
            end else chk("a_d1_missing", 32'd0, 32'd1);
            if (i < q3.size()) begin
                chk("a_d3_pc", q3[i].pc, 32'(i));
                chk("a_d3_word", q3[i].w, prog[i]);
                chk("a_d3_edge", 32'(q3[i].cyc), 32'(s + 5 + 5 * i));
            end else chk("a_d3_missing", 32'd0, 32'd1);
        end
        chk("a_d1_halted", 32'(h1), 32'd1);
        chk("a_d1_addr", ra1, 32'd3);
        chk("a_d3_halted", 32'(h3), 32'd1);
        chk("a_d3_addr", ra3, 32'd3);

        // Backpressure on the first word
        mem[3] = 32'h01050603;
        do_reset();
        q1.delete(); q3.delete();
        cycle(1'b1, 1'b0, 1'b0, 32'd0);
        wait_valid(1'b0, "b_valid_timeout");
        repeat (5) begin
            cycle(1'b0, 1'b0, 1'b0, 32'd0);
            chk("b_hold_valid", 32'(iv1), 32'd1);
            chk("b_hold_pc", ip1, 32'd0);
            chk("b_hold_word", io1, 32'h200400FF);
            chk("b_hold_addr", ra1, 32'd0);
        end
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        chk("b_addr_after_accept", ra1, 32'd1);

        // Redirect in the second cycle of the addr-1 fetch
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        q1.delete();
        cycle(1'b0, 1'b1, 1'b1, 32'd7);
        repeat (8) cycle(1'b0, 1'b1, 1'b0, 32'd0);
        chk("c_count", 32'(q1.size()), 32'd1);
        if (q1.size() > 0) begin
            chk("c_pc", q1[0].pc, 32'd7);
            chk("c_word", q1[0].w, 32'h41040703);
        end
        chk("c_halted", 32'(h1), 32'd1);
        chk("c_halt_addr", ra1, 32'd8);

        // Redirect coinciding with an accept
        q1.delete();
        cycle(1'b0, 1'b0, 1'b1, 32'd3);
        wait_valid(1'b0, "c2_valid_timeout");
        chk("c2_pc_before", ip1, 32'd3);
        cycle(1'b0, 1'b1, 1'b1, 32'd7);
        repeat (6) cycle(1'b0, 1'b1, 1'b0, 32'd0);
        chk("c2_count", 32'(q1.size()), 32'd2);
        if (q1.size() > 1) begin
            chk("c2_first_pc", q1[0].pc, 32'd3);
            chk("c2_first_word", q1[0].w, 32'h01050603);
            chk("c2_next_pc", q1[1].pc, 32'd7);
            chk("c2_next_word", q1[1].w, 32'h41040703);
        end

        // Restart out of HALT via redirect to 0
        cycle(1'b0, 1'b1, 1'b1, 32'd0);
        chk("d_halted_falls", 32'(h1), 32'd0);
        q1.delete();
        repeat (30) cycle(1'b0, 1'b1, 1'b0, 32'd0);
        chk("d_count", 32'(q1.size()), 32'd8);
        if (q1.size() > 0) begin
            chk("d_first_pc", q1[0].pc, 32'd0);
            chk("d_first_word", q1[0].w, 32'h200400FF);
        end

        // PC wrap past 0xFFFFFFFF
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF);
        wait_valid(1'b0, "w_valid_timeout");
        chk("w_pc", ip1, 32'hFFFFFFFF);
        chk("w_word", io1, mem[15]);
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        chk("w_addr_wrapped", ra1, 32'd0);

        // Async reset in the middle of a fetch
        cycle(1'b0, 1'b0, 1'b1, 32'd5);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        chk("e_addr_before", ra1, 32'd5);
        q1.delete();
        do_reset();
        repeat (8) cycle(1'b0, 1'b1, 1'b0, 32'd0);
        chk("e_no_handshake", 32'(q1.size()), 32'd0);
        chk("e_idle_valid", 32'(iv1), 32'd0);
        chk("e_idle_addr", ra1, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 16; i++)
            mem[i] = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom | 32'd1);
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                st  = ($urandom_range(0, 7) == 0);
                rdy = ($urandom_range(0, 3) != 0);
                rd  = ($urandom_range(0, 19) == 0);
                rpc = ($urandom_range(0, 5) == 0) ? (32'hFFFFFFFF - 32'($urandom_range(0, 1)))
                                                  : 32'($urandom_range(0, 15));
                cycle(st, rdy, rd, rpc);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
